mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences one instruction through FETCH/DECODE/EXE/MEM/WB.
- Drives the write enables, the immediate-extender mode (EXTOp) and the ALU, mux and next-PC selects.
- Stalls on memory-ready handshakes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- Op  input  6  IR[31:26], stable from DECODE onward
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU equality flag, valid in EXE
- IMReady  input  1  instruction memory data valid
- DMReady  input  1  data memory access complete
- PCWr  output  1  PC write enable
- IRWr  output  1  IR write enable
- RegWr  output  1  GRF write enable
- MemWr  output  1  DM write enable
- EXTOp  output  2  0 zero-ext, 1 sign-ext, 2 sign-ext<<2, 3 imm<<16
- ALUOp  output  3  0 add, 1 sub, 2 or
- ALUSrc  output  1  0 rt, 1 EXT output
- RegDst  output  2  0 rt, 1 rd, 2 $31
- WDSel  output  2  0 ALU, 1 DM, 2 latched PC+4, 3 EXT output
- NPCOp  output  2  0 PC+4, 1 branch, 2 j-target, 3 rs
- State  output  3  current state, debug
- InstrDone  output  1  one-cycle pulse on retirement
- Illegal  output  1  one-cycle pulse, unknown instruction
- RetireCnt  output  CNT_W  retired instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5–7 go to FETCH next cycle with all enables 0.
- Reset:
  - State=FETCH, RetireCnt=0.
  - While reset=1, all enables, InstrDone and Illegal are forced 0.
  - Reset in any state aborts the instruction; no partial writes.
- Outputs:
  - Combinational from State, Op, Funct and Zero.
  - Selects not listed for a state are 0.
- Instruction decode:
  - R-type (Op=000000): addu funct 100001, subu 100011, jr 001000.
  - I/J-type opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- FETCH:
  - Holds until IMReady=1.
  - In the IMReady cycle: IRWr=1, PCWr=1, NPCOp=0, then go to DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=2, go to FETCH, retire.
  - jal: PCWr=1, NPCOp=2, RegWr=1, RegDst=2, WDSel=2, go to FETCH, retire.
  - jr: PCWr=1, NPCOp=3, go to FETCH, retire.
  - Unknown Op, or Op=000000 with an unknown Funct: Illegal=1, go to FETCH, not retired, no writes.
  - All other decoded instructions: go to EXE.
- EXE, EXTOp/ALUOp/ALUSrc by instruction:
  - addu: ALUOp=0, ALUSrc=0.
  - subu: ALUOp=1, ALUSrc=0.
  - ori: EXTOp=0, ALUOp=2, ALUSrc=1.
  - lw/sw: EXTOp=1, ALUOp=0, ALUSrc=1.
  - beq: EXTOp=2, ALUOp=1, ALUSrc=0.
  - lui: EXTOp=3.
- EXE, next state:
  - beq: NPCOp=1, PCWr=Zero, go to FETCH, retire.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM:
  - Holds until DMReady=1.
  - Address selects (EXTOp=1, ALUSrc=1, ALUOp=0) stay asserted while held.
  - sw: MemWr=1 for every MEM cycle; on DMReady=1 go to FETCH, retire.
  - lw: on DMReady=1 go to WB.
- WB: RegWr=1, go to FETCH, retire. EXE selects stay held, plus:
  - addu/subu: RegDst=1, WDSel=0.
  - ori: RegDst=0, WDSel=0.
  - lui: RegDst=0, WDSel=3.
  - lw: RegDst=0, WDSel=1.
- Retirement:
  - InstrDone=1 in the last cycle of the instruction.
  - RetireCnt increments at that edge and wraps to 0 past all-ones.
- CPI with zero-wait memories: j/jal/jr 2, beq 3, addu/subu/ori/lui 4, sw 4, lw 5.
- Each wait cycle (IMReady=0 in FETCH, DMReady=0 in MEM) adds one cycle. No enables fire during waits except MemWr.

Test Plan:
- Reset held 2 cycles mid-EXE of addu → State=0, RetireCnt=0, RegWr=0 throughout. After release, FETCH with IMReady=1 → IRWr=PCWr=1.
- ori (Op=001101), zero-wait → states 0,1,2,4,0. EXTOp=0 in EXE/WB. RegWr=1 only in WB with RegDst=0. InstrDone once, RetireCnt=1.
- lw with DMReady low 3 cycles → MEM lasts 4 cycles, EXTOp=1 held. WB asserts WDSel=1, RegWr=1. Total 8 cycles.
- beq: Zero=1 → PCWr=1, NPCOp=1, EXTOp=2 in EXE. With Zero=0 → PCWr=0. Both retire in 3 cycles.
- jal → DECODE asserts PCWr=1, NPCOp=2, RegWr=1, RegDst=2, WDSel=2, then FETCH. Op=111111 → Illegal pulse, RetireCnt unchanged.
- Preload 1000 instructions (lui 250, sw 250, jr 250, subu 250) → RetireCnt=1000. Force CNT_W=4 → wraps 15→0.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle main controller for the MIPS datapath
// Sequences FETCH/DECODE/EXE/MEM/WB, drives datapath controls and counts retired instructions.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   input  logic             IMReady,
   input  logic             DMReady,
   output logic             PCWr,
   output logic             IRWr,
   output logic             RegWr,
   output logic             MemWr,
   output logic [1:0]       EXTOp,
   output logic [2:0]       ALUOp,
   output logic             ALUSrc,
   output logic [1:0]       RegDst,
   output logic [1:0]       WDSel,
   output logic [1:0]       NPCOp,
   output logic [2:0]       State,
   output logic             InstrDone,
   output logic             Illegal,
   output logic [CNT_W-1:0] RetireCnt
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXE    = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   logic is_rtype, is_addu, is_subu, is_jr;
   logic is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
   logic legal;

   assign is_rtype = (Op == 6'b000000);
   assign is_addu  = is_rtype && (Funct == 6'b100001);
   assign is_subu  = is_rtype && (Funct == 6'b100011);
   assign is_jr    = is_rtype && (Funct == 6'b001000);
   assign is_ori   = (Op == 6'b001101);
   assign is_lw    = (Op == 6'b100011);
   assign is_sw    = (Op == 6'b101011);
   assign is_beq   = (Op == 6'b000100);
   assign is_lui   = (Op == 6'b001111);
   assign is_j     = (Op == 6'b000010);
   assign is_jal   = (Op == 6'b000011);
   assign legal    = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                     is_beq | is_lui | is_j | is_jal;

   // Immediate/ALU selects chosen in EXE and held through MEM/WB
   logic [1:0] exe_ext;
   logic [2:0] exe_alu;
   logic       exe_src;

   assign exe_ext = is_lui ? 2'd3 : is_beq ? 2'd2 : (is_lw | is_sw) ? 2'd1 : 2'd0;
   assign exe_alu = is_ori ? 3'd2 : (is_subu | is_beq) ? 3'd1 : 3'd0;
   assign exe_src = is_ori | is_lw | is_sw;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic             pc_wr, ir_wr, reg_wr, mem_wr, done, illegal;
   logic [1:0]       ext_op, reg_dst, wd_sel, npc_op;
   logic [2:0]       alu_op;
   logic             alu_src;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt_d = done ? retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : retire_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (IMReady) state_d = S_DECODE;
         S_DECODE: state_d = (!legal || is_j || is_jal || is_jr) ? S_FETCH : S_EXE;
         S_EXE:    state_d = is_beq ? S_FETCH : (is_lw || is_sw) ? S_MEM : S_WB;
         S_MEM:    if (DMReady) state_d = is_lw ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      ext_op  = 2'd0;
      alu_op  = 3'd0;
      alu_src = 1'b0;
      reg_dst = 2'd0;
      wd_sel  = 2'd0;
      npc_op  = 2'd0;
      done    = 1'b0;
      illegal = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_wr = IMReady;
            pc_wr = IMReady;
         end
         S_DECODE: begin
            if (!legal) begin
               illegal = 1'b1;
            end else if (is_j || is_jal) begin
               pc_wr  = 1'b1;
               npc_op = 2'd2;
               done   = 1'b1;
               if (is_jal) begin
                  reg_wr  = 1'b1;
                  reg_dst = 2'd2;
                  wd_sel  = 2'd2;
               end
            end else if (is_jr) begin
               pc_wr  = 1'b1;
               npc_op = 2'd3;
               done   = 1'b1;
            end
         end
         S_EXE: begin
            ext_op  = exe_ext;
            alu_op  = exe_alu;
            alu_src = exe_src;
            if (is_beq) begin
               npc_op = 2'd1;
               pc_wr  = Zero;
               done   = 1'b1;
            end
         end
         S_MEM: begin
            ext_op  = 2'd1;
            alu_src = 1'b1;
            mem_wr  = is_sw;
            done    = is_sw && DMReady;
         end
         S_WB: begin
            ext_op  = exe_ext;
            alu_op  = exe_alu;
            alu_src = exe_src;
            reg_wr  = 1'b1;
            done    = 1'b1;
            reg_dst = (is_addu || is_subu) ? 2'd1 : 2'd0;
            wd_sel  = is_lui ? 2'd3 : is_lw ? 2'd1 : 2'd0;
         end
         default: ;
      endcase
   end

   // Reset blocks every write so an aborted instruction leaves no partial state
   assign PCWr      = pc_wr   & ~reset;
   assign IRWr      = ir_wr   & ~reset;
   assign RegWr     = reg_wr  & ~reset;
   assign MemWr     = mem_wr  & ~reset;
   assign InstrDone = done    & ~reset;
   assign Illegal   = illegal & ~reset;
   assign EXTOp     = ext_op;
   assign ALUOp     = alu_op;
   assign ALUSrc    = alu_src;
   assign RegDst    = reg_dst;
   assign WDSel     = wd_sel;
   assign NPCOp     = npc_op;
   assign State     = state_q;
   assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
// Per-instruction cycle schedules from a behavioural model, compared against both counter widths.
module tb_mc_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, IMReady, DMReady, Zero;
   logic [5:0]  Op, Funct;
   logic        PCWr, IRWr, RegWr, MemWr, ALUSrc, InstrDone, Illegal;
   logic [1:0]  EXTOp, RegDst, WDSel, NPCOp;
   logic [2:0]  ALUOp, State;
   logic [31:0] RetireCnt;

   logic        PCWr_4, IRWr_4, RegWr_4, MemWr_4, ALUSrc_4, InstrDone_4, Illegal_4;
   logic [1:0]  EXTOp_4, RegDst_4, WDSel_4, NPCOp_4;
   logic [2:0]  ALUOp_4, State_4;
   logic [3:0]  RetireCnt_4;

   mc_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .IMReady(IMReady), .DMReady(DMReady), .PCWr(PCWr), .IRWr(IRWr),
      .RegWr(RegWr), .MemWr(MemWr), .EXTOp(EXTOp), .ALUOp(ALUOp),
      .ALUSrc(ALUSrc), .RegDst(RegDst), .WDSel(WDSel), .NPCOp(NPCOp),
      .State(State), .InstrDone(InstrDone), .Illegal(Illegal), .RetireCnt(RetireCnt)
   );

   mc_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .IMReady(IMReady), .DMReady(DMReady), .PCWr(PCWr_4), .IRWr(IRWr_4),
      .RegWr(RegWr_4), .MemWr(MemWr_4), .EXTOp(EXTOp_4), .ALUOp(ALUOp_4),
      .ALUSrc(ALUSrc_4), .RegDst(RegDst_4), .WDSel(WDSel_4), .NPCOp(NPCOp_4),
      .State(State_4), .InstrDone(InstrDone_4), .Illegal(Illegal_4), .RetireCnt(RetireCnt_4)
   );

   typedef enum int {I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI,
                     I_J, I_JAL, I_ILL_OP, I_ILL_RND, I_ILL_FN} instr_e;

   typedef struct {
      logic [2:0] st;
      logic       pcwr, irwr, regwr, memwr;
      logic [1:0] ext;
      logic [2:0] alu;
      logic       src;
      logic [1:0] dst, wd, npc;
      logic       done, ill, imr, dmr;
   } rec_t;

   rec_t        sched[$];
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   int          checks, errors, exp_cnt;

   function automatic rec_t blank(logic [2:0] st);
      rec_t r;
      r = '{default: 0};
      r.st  = st;
      r.imr = 1'($urandom_range(0, 1));
      r.dmr = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic logic [1:0] m_ext(instr_e c);
      case (c)
         I_LW, I_SW: return 2'd1;
         I_BEQ:      return 2'd2;
         I_LUI:      return 2'd3;
         default:    return 2'd0;
      endcase
   endfunction

   function automatic logic [2:0] m_alu(instr_e c);
      case (c)
         I_SUBU, I_BEQ: return 3'd1;
         I_ORI:         return 3'd2;
         default:       return 3'd0;
      endcase
   endfunction

   function automatic logic m_src(instr_e c);
      return (c == I_ORI || c == I_LW || c == I_SW);
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction, waits included
   function automatic void build(instr_e c, logic z, int imw, int dmw);
      rec_t r;
      for (int i = 0; i < imw; i++) begin
         r = blank(3'd0); r.imr = 1'b0; sched.push_back(r);
      end
      r = blank(3'd0); r.imr = 1'b1; r.irwr = 1'b1; r.pcwr = 1'b1; sched.push_back(r);
      r = blank(3'd1);
      case (c)
         I_J, I_JAL: begin
            r.pcwr = 1'b1; r.npc = 2'd2; r.done = 1'b1;
            if (c == I_JAL) begin r.regwr = 1'b1; r.dst = 2'd2; r.wd = 2'd2; end
            sched.push_back(r); return;
         end
         I_JR: begin
            r.pcwr = 1'b1; r.npc = 2'd3; r.done = 1'b1; sched.push_back(r); return;
         end
         I_ILL_OP, I_ILL_RND, I_ILL_FN: begin
            r.ill = 1'b1; sched.push_back(r); return;
         end
         default: sched.push_back(r);
      endcase
      r = blank(3'd2); r.ext = m_ext(c); r.alu = m_alu(c); r.src = m_src(c);
      if (c == I_BEQ) begin
         r.npc = 2'd1; r.pcwr = z; r.done = 1'b1; sched.push_back(r); return;
      end
      sched.push_back(r);
      if (c == I_LW || c == I_SW) begin
         for (int i = 0; i <= dmw; i++) begin
            r = blank(3'd3); r.dmr = (i == dmw); r.ext = 2'd1; r.src = 1'b1;
            r.memwr = (c == I_SW); r.done = (c == I_SW) && (i == dmw);
            sched.push_back(r);
         end
         if (c == I_SW) return;
      end
      r = blank(3'd4); r.ext = m_ext(c); r.alu = m_alu(c); r.src = m_src(c);
      r.regwr = 1'b1; r.done = 1'b1;
      r.dst = (c == I_ADDU || c == I_SUBU) ? 2'd1 : 2'd0;
      r.wd  = (c == I_LUI) ? 2'd3 : (c == I_LW) ? 2'd1 : 2'd0;
      sched.push_back(r);
   endfunction

   function automatic logic [63:0] pack_exp(rec_t r, int cnt);
      logic [31:0] c;
      c = cnt;
      return {7'd0, c[3:0], c, r.st, r.pcwr, r.irwr, r.regwr, r.memwr, r.ext,
              r.alu, r.src, r.dst, r.wd, r.npc, r.done, r.ill};
   endfunction

   task automatic set_instr(instr_e c);
      logic [5:0] v;
      Funct = 6'($urandom);
      case (c)
         I_ADDU: begin Op = 6'b000000; Funct = 6'b100001; end
         I_SUBU: begin Op = 6'b000000; Funct = 6'b100011; end
         I_JR:   begin Op = 6'b000000; Funct = 6'b001000; end
         I_ORI:  Op = 6'b001101;
         I_LW:   Op = 6'b100011;
         I_SW:   Op = 6'b101011;
         I_BEQ:  Op = 6'b000100;
         I_LUI:  Op = 6'b001111;
         I_J:    Op = 6'b000010;
         I_JAL:  Op = 6'b000011;
         I_ILL_OP: Op = 6'b111111;
         I_ILL_RND: begin
            do v = 6'($urandom);
            while (v inside {6'b000000, 6'b001101, 6'b100011, 6'b101011,
                             6'b000100, 6'b001111, 6'b000010, 6'b000011});
            Op = v;
         end
         default: begin
            Op = 6'b000000;
            do v = 6'($urandom);
            while (v inside {6'b100001, 6'b100011, 6'b001000});
            Funct = v;
         end
      endcase
   endtask

   // Starts and ends at posedge+1; records expected and observed vectors per cycle
   task automatic run_instr(instr_e c, logic z, int imw, int dmw);
      sched.delete();
      build(c, z, imw, dmw);
      set_instr(c);
      foreach (sched[i]) begin
         IMReady = sched[i].imr;
         DMReady = sched[i].dmr;
         Zero    = z;
         @(negedge clk);
         exp_q.push_back(pack_exp(sched[i], exp_cnt));
         obs_q.push_back({7'd0, RetireCnt_4, RetireCnt, State, PCWr, IRWr, RegWr, MemWr,
                          EXTOp, ALUOp, ALUSrc, RegDst, WDSel, NPCOp, InstrDone, Illegal});
         if (sched[i].done) exp_cnt++;
         @(posedge clk); #1;
      end
      IMReady = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      IMReady = 1'b1;
      @(negedge clk);
      checks++;
      if (State !== 3'd0 || RetireCnt !== 32'd0 || RetireCnt_4 !== 4'd0) begin
         errors++; $display("FAIL reset_state got state %0d cnt %0d/%0d want 0 0/0", State, RetireCnt, RetireCnt_4);
      end
      checks++;
      if ({PCWr, IRWr, RegWr, MemWr, InstrDone, Illegal} !== 6'b0) begin
         errors++; $display("FAIL reset_enables got %b want 000000", {PCWr, IRWr, RegWr, MemWr, InstrDone, Illegal});
      end
      @(posedge clk); #1;
      reset = 1'b0; Op = 6'b000000; Funct = 6'b100001;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (State !== 3'd2 || {PCWr, IRWr, RegWr, MemWr, InstrDone} !== 5'b0) begin
         errors++; $display("FAIL reset_in_exe got state %0d en %b want 2 00000", State, {PCWr, IRWr, RegWr, MemWr, InstrDone});
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (State !== 3'd0 || {PCWr, IRWr, RegWr, MemWr, InstrDone} !== 5'b0 || RetireCnt !== 32'd0) begin
         errors++; $display("FAIL reset_held got state %0d en %b cnt %0d want 0 00000 0", State, {PCWr, IRWr, RegWr, MemWr, InstrDone}, RetireCnt);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (State !== 3'd0 || IRWr !== 1'b1 || PCWr !== 1'b1 || RegWr !== 1'b0 || RetireCnt !== 32'd0) begin
         errors++; $display("FAIL reset_release got state %0d irwr %b pcwr %b regwr %b cnt %0d want 0 1 1 0 0", State, IRWr, PCWr, RegWr, RetireCnt);
      end
      @(posedge clk); #1;
      reset = 1'b1; IMReady = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; exp_cnt = 0;
   endtask

   task automatic test_ori();
      exp_q.delete(); obs_q.delete();
      run_instr(I_ORI, 1'b0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ori_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if ({obs_q[0][20:18], obs_q[1][20:18], obs_q[2][20:18], obs_q[3][20:18]} !== 12'o0124) begin
         errors++; $display("FAIL ori_states got %o want 0124", {obs_q[0][20:18], obs_q[1][20:18], obs_q[2][20:18], obs_q[3][20:18]});
      end
      @(negedge clk);
      checks++;
      if (RetireCnt !== 32'd1) begin errors++; $display("FAIL ori_retire got %0d want 1", RetireCnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_lw_wait();
      int mem_cycles, done_at;
      exp_q.delete(); obs_q.delete();
      run_instr(I_LW, 1'b0, 0, 3);
      mem_cycles = 0; done_at = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lw_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         if (obs_q[i][20:18] == 3'd3) mem_cycles++;
         if (obs_q[i][1] && done_at < 0) done_at = i;
      end
      checks++;
      if (mem_cycles != 4) begin errors++; $display("FAIL lw_mem_len got %0d want 4", mem_cycles); end
      checks++;
      if (done_at != 7) begin errors++; $display("FAIL lw_done_cycle got %0d want 7", done_at); end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         exp_q.delete(); obs_q.delete();
         run_instr(I_BEQ, 1'(z), 0, 0);
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL beq%0d_cycle%0d got %h want %h", z, i, obs_q[i], exp_q[i]); end
         end
         checks++;
         if (obs_q[2][17] !== 1'(z) || obs_q[2][3:2] !== 2'd1 || obs_q[2][13:12] !== 2'd2 || obs_q[2][1] !== 1'b1) begin
            errors++; $display("FAIL beq%0d_exe got pcwr %b npc %0d ext %0d done %b want %0d 1 2 1", z, obs_q[2][17], obs_q[2][3:2], obs_q[2][13:12], obs_q[2][1], z);
         end
      end
   endtask

   task automatic test_jal_illegal();
      int ills;
      exp_q.delete(); obs_q.delete();
      run_instr(I_JAL, 1'b0, 0, 0);
      checks++;
      if ({obs_q[1][17], obs_q[1][3:2], obs_q[1][15], obs_q[1][7:6], obs_q[1][5:4], obs_q[1][1]} !== 9'b1_10_1_10_10_1) begin
         errors++; $display("FAIL jal_decode got %b want 110110101", {obs_q[1][17], obs_q[1][3:2], obs_q[1][15], obs_q[1][7:6], obs_q[1][5:4], obs_q[1][1]});
      end
      run_instr(I_ILL_OP, 1'b0, 1, 0);
      ills = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL jal_ill_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         ills += int'(obs_q[i][0]);
      end
      checks++;
      if (ills != 1) begin errors++; $display("FAIL illegal_pulses got %0d want 1", ills); end
      @(negedge clk);
      checks++;
      if (RetireCnt !== 32'(exp_cnt)) begin errors++; $display("FAIL illegal_retire got %0d want %0d", RetireCnt, exp_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      exp_q.delete(); obs_q.delete();
      for (int n = 0; n < 300; n++)
         run_instr(instr_e'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_bulk();
      instr_e mix[4];
      mix = '{I_LUI, I_SW, I_JR, I_SUBU};
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; exp_cnt = 0;
      exp_q.delete(); obs_q.delete();
      for (int n = 0; n < 1000; n++) run_instr(mix[n % 4], 1'b0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bulk_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      @(negedge clk);
      checks++;
      if (RetireCnt !== 32'd1000) begin errors++; $display("FAIL bulk_retire got %0d want 1000", RetireCnt); end
      checks++;
      if (RetireCnt_4 !== 4'd8) begin errors++; $display("FAIL bulk_retire_w4 got %0d want 8", RetireCnt_4); end
   endtask

   initial begin
      checks = 0; errors = 0; exp_cnt = 0;
      reset = 1'b1; IMReady = 1'b0; DMReady = 1'b0; Zero = 1'b0;
      Op = 6'b000000; Funct = 6'b000000;
      test_reset();
      test_ori();
      test_lw_wait();
      test_beq();
      test_jal_illegal();
      test_random();
      test_bulk();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
